fir_lut_loader: RTL and testbench
=================================

Name: fir_lut_loader

Overview:
- On-chip writer for the fir_filter distributed-arithmetic coefficient LUT. It drives the CIN/CADDR/CLOAD port that fir_filter uses to receive its LUT.
- Collects 64 signed 16-bit tap coefficients over a valid/ready stream, then precomputes all 2048 partial sums (8 groups x 256 addresses).
- Streams one entry per clock into fir_filter's load port, so the filter needs no host-side LUT precompute.

Parameters:
- NTAPS, 64, number of filter taps; must equal NGRP*GSIZE.
- GSIZE, 8, taps per DA group; each group owns 2^GSIZE LUT entries.
- COEF_W, 16, signed coefficient width.
- LUT_W, 19, signed LUT entry width; equals COEF_W+log2(GSIZE).
- ADDR_W, 11, LUT address width; equals log2(NTAPS/GSIZE)+GSIZE.

Ports:
- clk_slow, input, 1, sole clock; everything is sampled on its rising edge.
- resetn, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that begins coefficient collection.
- coef_in, input, COEF_W, signed coefficient; tap 0 arrives first.
- coef_valid, input, 1, coef_in is valid.
- coef_ready, output, 1, loader accepts a coefficient this cycle.
- CIN, output, LUT_W, signed LUT entry to fir_filter.
- CADDR, output, ADDR_W, LUT address to fir_filter.
- CLOAD, output, 1, high exactly while CIN/CADDR carry valid entries.
- busy, output, 1, high in COLLECT, STREAM or FLUSH.
- done, output, 1, one-cycle pulse after the last entry.

Behaviour:
- Reset values: coef_ready=0, CIN=0, CADDR=0, CLOAD=0, busy=0, done=0, state=IDLE. The coefficient register file is cleared to 0.
- States: IDLE, COLLECT, STREAM, FLUSH.
- IDLE -> COLLECT on start. The tap counter clears to 0.
- COLLECT: coef_ready=1. Each cycle with coef_valid&&coef_ready writes coef[tap] and increments tap. The 64th accepted coefficient moves the block to STREAM on the next cycle; coef_ready drops in that same cycle.
- Entry arithmetic: index n runs 0..2047, group k=n[10:8], bits a=n[7:0]. entry(n) is the sum over b=0..7 of (a[b] ? coef[k*8+b] : 0).
  - Sign-extend every coefficient to LUT_W before adding.
  - The result is exact with no saturation. Range is -262144..+262136.
- Pipeline: stage 1 registers n and muxes out the 8 group coefficients. Stage 2 is the adder tree, registered into CIN and CADDR=n.
  - CADDR/CIN for index n appear 2 cycles after n is issued.
  - CLOAD rises with CADDR=0 and stays high for exactly 2048 consecutive cycles, ending with CADDR=2047.
- STREAM issues n=0..2047, one per cycle with no gaps, then moves to FLUSH.
- FLUSH drains the pipeline. On the cycle after the last entry, CLOAD=0 and done=1 for 1 cycle, then the block returns to IDLE. CIN/CADDR hold their last values.
- start while busy is ignored.
- coef_valid outside COLLECT is ignored (coef_ready=0).
- coef_valid and start in the same cycle as IDLE->COLLECT: the coefficient is not accepted, because coef_ready is still 0.
- resetn low at any point: all outputs return to reset values immediately (asynchronous). A partial load is abandoned, and the next start restarts at tap 0.
- The coefficient file persists across loads. A new start overwrites all 64 coefficients.

Optional Feature:
- Macro: FIR_LUT_CHECKSUM_EN.
- Defined: adds output lut_sum [31:0]. It clears on start and accumulates the sign-extended CIN every cycle CLOAD=1. The value is stable from the done pulse until the next start.
- Undefined: no port and no accumulator logic.

Decomposition:
- Shared package fir_pkg holds:
  - COEF_W, LUT_W, ADDR_W, NTAPS, GSIZE;
  - the state enum {IDLE, COLLECT, STREAM, FLUSH};
  - the entry-count constant 2048.
- One sub-module, fir_lut_adder8: a registered 8-input signed adder tree with a bit-mask select. This is stage 2.

Test Plan:
- All coefs = 1 -> CIN at CADDR n equals popcount(n[7:0]); CADDR 255 gives 8 and CADDR 256 gives 0. CLOAD is high for exactly 2048 cycles, and done pulses once.
- All coefs = -32768 -> CADDR 255, 511, ..., 2047 give -262144. All coefs = 32767 -> the same addresses give 262136, with no wrap.
- Random coefs with coef_valid toggled randomly -> every entry matches the software DA sum. No coefficient is dropped or duplicated, and there are 64 accepted handshakes.
- resetn pulsed low at CADDR=1000 -> CLOAD=0 and busy=0 asynchronously. A new start and a full reload complete correctly.
- start pulsed during STREAM, and coef_valid held high during STREAM -> both are ignored; the stream and the coefficients are unchanged.
- With FIR_LUT_CHECKSUM_EN, all coefs = 1 -> lut_sum = 8 groups x 1024 = 8192 at done.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, state encoding and stage-1 payload for the fir_filter LUT loader.
package fir_pkg;

  localparam int unsigned NTAPS    = 64;
  localparam int unsigned GSIZE    = 8;
  localparam int unsigned COEF_W   = 16;
  localparam int unsigned LUT_W    = 19;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned TAP_W    = $clog2(NTAPS);
  localparam int unsigned GBIT_W   = $clog2(GSIZE);
  localparam int unsigned NENTRIES = 2048;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STREAM  = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  // One LUT index plus the eight coefficients of its group.
  typedef struct packed {
    logic [ADDR_W-1:0]             n;
    logic [GSIZE-1:0][COEF_W-1:0]  coefs;
  } grp_t;

  function automatic logic [LUT_W-1:0] sext_coef(input logic [COEF_W-1:0] c);
    return {{(LUT_W-COEF_W){c[COEF_W-1]}}, c};
  endfunction

endpackage

// File: rtl/fir_lut_adder8.sv
// Registered 8-input signed adder tree; bit b of the index selects coefficient b.
module fir_lut_adder8
  import fir_pkg::*;
(
  input  logic              clk_slow,
  input  logic              resetn,
  input  logic              in_valid,
  input  grp_t              grp,
  output logic [LUT_W-1:0]  sum,
  output logic [ADDR_W-1:0] addr,
  output logic              out_valid
);

  logic [LUT_W-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int unsigned b = 0; b < GSIZE; b++) begin
      if (grp.n[b]) begin
        sum_c = sum_c + sext_coef(grp.coefs[b]);
      end
    end
  end

  // Sum and address hold their last values once the stream stops.
  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      sum       <= '0;
      addr      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_c;
        addr <= grp.n;
      end
    end
  end

endmodule

// File: rtl/fir_lut_loader.sv
// Collects 64 taps and streams the 2048-entry DA LUT into fir_filter's load port.
// Optional FIR_LUT_CHECKSUM_EN adds the lut_sum accumulator output.
module fir_lut_loader
  import fir_pkg::*;
(
  input  logic              clk_slow,
  input  logic              resetn,
  input  logic              start,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [LUT_W-1:0]  CIN,
  output logic [ADDR_W-1:0] CADDR,
  output logic              CLOAD,
  output logic              busy,
  output logic              done
`ifdef FIR_LUT_CHECKSUM_EN
  ,
  output logic [31:0]       lut_sum
`endif
);

  state_t            state_q, state_d;
  logic [TAP_W-1:0]  tap_q;
  logic [ADDR_W-1:0] n_q;
  logic [COEF_W-1:0] coef_q [NTAPS];
  grp_t              s1_q, s1_d;
  logic              s1_valid_q;
  logic              ready_d, busy_d, done_d;

  logic accept_c, last_tap_c, last_n_c;
  assign accept_c   = coef_valid && coef_ready;
  assign last_tap_c = accept_c && (tap_q == TAP_W'(NTAPS-1));
  assign last_n_c   = (n_q == ADDR_W'(NENTRIES-1));

  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = COLLECT;
      COLLECT: if (last_tap_c) state_d = STREAM;
      STREAM:  if (last_n_c)   state_d = FLUSH;
      FLUSH:   if (done)       state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Done fires the cycle after the last entry leaves stage 2.
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = (state_d == COLLECT);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == FLUSH) && CLOAD && !s1_valid_q;
  end

  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      coef_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      coef_ready <= ready_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Coefficient capture and LUT index counter.
  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      tap_q <= '0;
      n_q   <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) coef_q[i] <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        tap_q <= '0;
        n_q   <= '0;
      end
      if (accept_c) begin
        coef_q[tap_q] <= coef_in;
        tap_q         <= tap_q + TAP_W'(1);
      end
      if (state_q == STREAM) n_q <= n_q + ADDR_W'(1);
    end
  end

  always_comb begin
    s1_d   = '0;
    s1_d.n = n_q;
    for (int unsigned b = 0; b < GSIZE; b++) begin
      s1_d.coefs[b] = coef_q[{n_q[ADDR_W-1:GSIZE], GBIT_W'(b)}];
    end
  end

  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= (state_q == STREAM);
      if (state_q == STREAM) s1_q <= s1_d;
    end
  end

  fir_lut_adder8 u_adder (
    .clk_slow  (clk_slow),
    .resetn    (resetn),
    .in_valid  (s1_valid_q),
    .grp       (s1_q),
    .sum       (CIN),
    .addr      (CADDR),
    .out_valid (CLOAD)
  );

`ifdef FIR_LUT_CHECKSUM_EN
  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      lut_sum <= '0;
    end else if (state_q == IDLE && start) begin
      lut_sum <= '0;
    end else if (CLOAD) begin
      lut_sum <= lut_sum + {{(32-LUT_W){CIN[LUT_W-1]}}, CIN};
    end
  end
`endif

endmodule

// File: tb/tb_fir_lut_loader.sv
// Scoreboard bench for fir_lut_loader: random taps against a plain DA-sum model.
module tb_fir_lut_loader;

  logic        clk_slow = 1'b0;
  logic        resetn;
  logic        start;
  logic [15:0] coef_in;
  logic        coef_valid;
  logic        coef_ready;
  logic [18:0] CIN;
  logic [10:0] CADDR;
  logic        CLOAD;
  logic        busy;
  logic        done;
`ifdef FIR_LUT_CHECKSUM_EN
  logic [31:0] lut_sum;
`endif

  always #5 clk_slow = ~clk_slow;

  fir_lut_loader dut (
    .clk_slow   (clk_slow),
    .resetn     (resetn),
    .start      (start),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .CIN        (CIN),
    .CADDR      (CADDR),
    .CLOAD      (CLOAD),
    .busy       (busy),
    .done       (done)
`ifdef FIR_LUT_CHECKSUM_EN
    ,
    .lut_sum    (lut_sum)
`endif
  );

  typedef struct {
    int addr;
    int cin;
  } exp_t;

  exp_t   exp_q[$];
  int     assert_cnt = 0;
  int     fail_cnt   = 0;
  int     cyc        = 0;
  int     cload_cnt  = 0;
  int     done_cnt   = 0;
  int     first_cyc  = 0;
  int     last_cyc   = 0;
  int     done_cyc   = 0;
  longint exp_sum    = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Entry n = sum of the group's coefficients whose bit is set in n[7:0].
  function automatic int da_entry(input int n, input int c[64]);
    int s = 0;
    int k = n / 256;
    int a = n % 256;
    for (int b = 0; b < 8; b++) begin
      if (((a >> b) & 1) == 1) s += c[k*8 + b];
    end
    return s;
  endfunction

  // Monitor: every CLOAD beat is matched against the scoreboard head.
  always @(negedge clk_slow) begin
    exp_t e;
    cyc++;
    if (resetn === 1'b1) begin
      if (CLOAD) begin
        if (cload_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        cload_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_cload", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("caddr", CADDR, e.addr);
          check("cin", $signed(CIN), e.cin);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Start a load and hand over all 64 taps with randomly gapped valid.
  task automatic collect(input int c[64], input int pct);
    int idx = 0;
    int guard = 0;
    bit first = 1'b1;
    bit v;
    exp_sum = 0;
    for (int n = 0; n < 2048; n++) begin
      exp_t e;
      e.addr = n;
      e.cin  = da_entry(n, c);
      exp_q.push_back(e);
      exp_sum += e.cin;
    end
    cload_cnt = 0;
    done_cnt  = 0;
    while (idx < 64 && guard < 3000) begin
      @(negedge clk_slow);
      guard++;
      start = first;
      v = first || ($urandom_range(99) < pct);
      first = 1'b0;
      coef_valid = v;
      coef_in = v ? 16'(c[idx]) : 16'($urandom);
      if (v && coef_ready) idx++;
    end
    check("taps_accepted", idx, 64);
    @(negedge clk_slow);
    start = 1'b0;
    coef_valid = 1'b0;
    check("ready_drop", coef_ready, 0);
    check("busy_stream", busy, 1);
  endtask

  task automatic run_load(input int c[64], input int pct, input bit poke);
    int guard = 0;
    collect(c, pct);
    while (done_cnt == 0 && guard < 5000) begin
      @(negedge clk_slow);
      guard++;
      start = poke && (guard == 600);
      coef_valid = poke;
      coef_in = 16'($urandom);
    end
    start = 1'b0;
    coef_valid = 1'b0;
    repeat (4) @(negedge clk_slow);
    #1;
    check("done_pulses", done_cnt, 1);
    check("cload_beats", cload_cnt, 2048);
    check("cload_span", last_cyc - first_cyc, 2047);
    check("done_after_last", done_cyc - last_cyc, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    check("busy_idle", busy, 0);
    check("hold_caddr", CADDR, 2047);
`ifdef FIR_LUT_CHECKSUM_EN
    check("lut_sum", lut_sum, exp_sum[31:0]);
`endif
  endtask

  task automatic rand_coefs(output int c[64]);
    logic signed [15:0] r;
    for (int i = 0; i < 64; i++) begin
      r = 16'($urandom);
      c[i] = r;
    end
  endtask

  initial begin
    int c[64];
    int guard;
    resetn = 1'b0;
    start = 1'b0;
    coef_valid = 1'b0;
    coef_in = '0;
    #12;
    check("rst_coef_ready", coef_ready, 0);
    check("rst_cin", CIN, 0);
    check("rst_caddr", CADDR, 0);
    check("rst_cload", CLOAD, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk_slow);
    resetn = 1'b1;

    foreach (c[i]) c[i] = 1;
    run_load(c, 100, 1'b0);
    foreach (c[i]) c[i] = -32768;
    run_load(c, 70, 1'b0);
    foreach (c[i]) c[i] = 32767;
    run_load(c, 100, 1'b0);
    rand_coefs(c);
    run_load(c, 40, 1'b0);

    // Abandon a stream mid-way with an asynchronous reset.
    rand_coefs(c);
    collect(c, 50);
    guard = 0;
    while (!(CLOAD && CADDR == 11'd1000) && guard < 3000) begin
      @(negedge clk_slow);
      guard++;
    end
    check("reach_caddr_1000", CADDR, 1000);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_cload", CLOAD, 0);
    check("arst_busy", busy, 0);
    check("arst_caddr", CADDR, 0);
    check("arst_cin", CIN, 0);
    check("arst_ready", coef_ready, 0);
    exp_q.delete();
    repeat (2) @(negedge clk_slow);
    resetn = 1'b1;
    rand_coefs(c);
    run_load(c, 80, 1'b0);

    // start and coef_valid poked during the stream must change nothing.
    rand_coefs(c);
    run_load(c, 60, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", fail_cnt);
    $fatal(1);
  end

endmodule
